// File: rtl/dexec_pkg.sv
// dexec_pkg: shared opcodes, flag bits, instruction fields and FSM encoding for dexec_stage
package dexec_pkg;
    localparam int DATA_W = 8;
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_ADD = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam int FL_Z = 0;
    localparam int FL_C = 1;
    localparam int FL_S = 2;
    localparam int FL_V = 3;
    localparam int OP_LO  = 16;
    localparam int RD_LO  = 14;
    localparam int RA_LO  = 12;
    localparam int RB_LO  = 10;
    localparam int IMM_EN = 9;
    localparam int RSVD   = 8;
    localparam int IMM_LO = 0;
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
endpackage

// File: rtl/dexec_regfile.sv
// dregfile4: 4x8 register file, one synchronous write port, two operand reads and a debug read
module dregfile4 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        ra_addr,
    input  logic [1:0]        rb_addr,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] dbg_data
);
    logic [DATA_W-1:0] regs [4];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end
    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign dbg_data = regs[dbg_addr];
endmodule

// File: rtl/dexec_stage.sv
// dexec_stage: single-issue execute stage driving an external dALU and writing results back
module dexec_stage
    import dexec_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [19:0]       in_instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [3:0]        alu_flags,
    output logic              done,
    output logic [1:0]        done_rd,
    output logic [DATA_W-1:0] done_data,
    output logic              err,
    output logic [3:0]        flags_q,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    state_t            state;
    logic [19:0]       instr_q;
    logic [DATA_W-1:0] res_q;
    logic [3:0]        fl_q;
    logic [DATA_W-1:0] ra_data, rb_data;
    logic [3:0]        op;
    logic [1:0]        rd, ra, rb;
    logic [7:0]        imm;
    logic              use_imm, legal, wr_en, in_exec, unused_rsvd;
    assign op          = instr_q[OP_LO +: 4];
    assign rd          = instr_q[RD_LO +: 2];
    assign ra          = instr_q[RA_LO +: 2];
    assign rb          = instr_q[RB_LO +: 2];
    assign use_imm     = instr_q[IMM_EN];
    assign imm         = instr_q[IMM_LO +: 8];
    assign unused_rsvd = instr_q[RSVD];
    assign legal       = (op != OP_NOP) && (op <= OP_SHL);
    assign in_exec     = state == EXEC;
    assign wr_en       = (state == WB) && legal;
    assign in_ready    = !in_exec;
    assign alu_a       = in_exec ? ra_data : '0;
    assign alu_b       = in_exec ? (use_imm ? DATA_W'(imm) : rb_data) : '0;
    assign alu_op      = in_exec ? op : '0;
    assign done_rd     = rd;
    assign done_data   = res_q;
    dregfile4 #(.DATA_W(DATA_W)) u_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wr_en),
        .waddr    (rd),
        .wdata    (res_q),
        .ra_addr  (ra),
        .rb_addr  (rb),
        .dbg_addr (dbg_addr),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .dbg_data (dbg_data)
    );
    // done/err are registered on the EXEC->WB edge so they are high exactly for the WB cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            instr_q <= '0;
            res_q   <= '0;
            fl_q    <= '0;
            flags_q <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        instr_q <= in_instr;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    res_q <= alu_out;
                    fl_q  <= alu_flags;
                    done  <= legal;
                    err   <= op[3];
                    state <= WB;
                end
                WB: begin
                    if (legal) flags_q <= fl_q;
                    if (in_valid) instr_q <= in_instr;
                    state <= in_valid ? EXEC : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
